// File: rtl/osd_event_sample_buffer_pkg.sv
// Shared constants and helpers for the debug event sample buffer.
// Holds the drop-counter width and its saturating increment.
package osd_event_sample_buffer_pkg;

    // Width of one event word and of the drop counter.
    localparam int WORD_W    = 16;
    localparam int OVF_CNT_W = 16;

    // Add one to the drop counter, holding at all-ones.
    function automatic logic [OVF_CNT_W-1:0] sat_inc(
        input logic [OVF_CNT_W-1:0] v
    );
        if (v == {OVF_CNT_W{1'b1}})
            return v;
        return v + OVF_CNT_W'(1);
    endfunction

endpackage

// File: rtl/osd_event_fifo.sv
// Synchronous first-word-fall-through FIFO for event entries.
// Ports: clk, rst (sync, active-high), wr_en/wr_data, rd_en/rd_data,
// empty, full, can_write (= !full | rd_en).
module osd_event_fifo
    import osd_event_sample_buffer_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic             can_write
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign can_write = !full | rd_en;

    // A pop on an empty FIFO is ignored.
    assign do_rd = rd_en & !empty;
    assign do_wr = wr_en & can_write;

    // Head is read combinationally: the FWFT view.
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_rd)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/osd_event_sample_buffer.sv
// Capture stage ahead of the debug event packetizer: buffers trace
// samples in a FWFT FIFO and inserts overflow records for drops.
// Ports: clk, rst (sync, active-high); sample_data/sample_valid in;
// event_available, overflow, data_num_words, data out;
// event_consumed, data_req_idx, data_req_valid in.
module osd_event_sample_buffer
    import osd_event_sample_buffer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           sample_data,
    input  logic                       sample_valid,
    output logic                       event_available,
    input  logic                       event_consumed,
    output logic                       overflow,
    output logic [$clog2(WIDTH/16+1)-1:0] data_num_words,
    input  logic [((WIDTH/16) > 1 ? $clog2(WIDTH/16) : 1)-1:0] data_req_idx,
    input  logic                       data_req_valid,
    output logic [WORD_W-1:0]          data
);

    localparam int NW   = WIDTH / WORD_W;
    localparam int IDXW = (NW > 1) ? $clog2(NW) : 1;
    localparam int NWW  = $clog2(NW + 1);
    localparam int EW   = WIDTH + 1;

    logic [OVF_CNT_W-1:0] ov_cnt;
    logic [OVF_CNT_W-1:0] ov_cnt_d;
    logic                 wr_en;
    logic [EW-1:0]        wr_data;
    logic [EW-1:0]        head;
    logic                 empty;
    logic                 full;
    logic                 slot;
    logic                 pop;
    logic                 ov_pend;
    logic                 ovf_wr;
    logic                 smp_wr;
    logic                 drop;
    logic [WORD_W-1:0]    word;

    // The request qualifier carries no state effect here.
    logic unused_ok;
    assign unused_ok = data_req_valid ^ full;

    assign pop = event_consumed & !empty;

    osd_event_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (pop),
        .rd_data   (head),
        .empty     (empty),
        .full      (full),
        .can_write (slot)
    );

    // Pending overflow record wins the slot over a new sample.
    assign ov_pend = (ov_cnt != '0);
    assign ovf_wr  = ov_pend & slot;
    assign smp_wr  = !ov_pend & sample_valid & slot;
    assign drop    = sample_valid & !slot;

    always_comb begin
        wr_en    = 1'b0;
        wr_data  = '0;
        ov_cnt_d = ov_cnt;
        unique case (1'b1)
            ovf_wr: begin
                wr_en          = 1'b1;
                wr_data[EW-1]  = 1'b1;
                wr_data[15:0]  = ov_cnt;
                // A sample colliding with the record is itself a drop.
                ov_cnt_d = sample_valid ? OVF_CNT_W'(1) : '0;
            end
            smp_wr: begin
                wr_en   = 1'b1;
                wr_data = {1'b0, sample_data};
            end
            drop: begin
                ov_cnt_d = sat_inc(ov_cnt);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            ov_cnt <= '0;
        else
            ov_cnt <= ov_cnt_d;
    end

    // Head word select; indices past the sample return zero.
    always_comb begin
        word = '0;
        for (int i = 0; i < NW; i++) begin
            if (data_req_idx == IDXW'(i))
                word = head[WORD_W*i +: WORD_W];
        end
    end

    assign event_available = !empty;
    assign overflow        = head[EW-1] & !empty;

    always_comb begin
        data           = '0;
        data_num_words = NWW'(NW);
        if (overflow) begin
            data           = head[15:0];
            data_num_words = NWW'(1);
        end else if (!empty) begin
            data = word;
        end
    end

endmodule

// File: tb/tb_osd_event_sample_buffer.sv
// Directed self-checking bench for osd_event_sample_buffer
// (WIDTH=32, DEPTH=16) using immediate assertions.
module tb_osd_event_sample_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sample_data;
    logic        sample_valid;
    logic        event_available;
    logic        event_consumed;
    logic        overflow;
    logic [1:0]  data_num_words;
    logic [0:0]  data_req_idx;
    logic        data_req_valid;
    logic [15:0] data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    osd_event_sample_buffer #(
        .WIDTH (32),
        .DEPTH (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sample_data     (sample_data),
        .sample_valid    (sample_valid),
        .event_available (event_available),
        .event_consumed  (event_consumed),
        .overflow        (overflow),
        .data_num_words  (data_num_words),
        .data_req_idx    (data_req_idx),
        .data_req_valid  (data_req_valid),
        .data            (data)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        sample_data  = v;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic pop();
        event_consumed = 1'b1;
        tick();
        event_consumed = 1'b0;
    endtask

    task automatic push_pop(input logic [31:0] v);
        sample_data    = v;
        sample_valid   = 1'b1;
        event_consumed = 1'b1;
        tick();
        sample_valid   = 1'b0;
        event_consumed = 1'b0;
    endtask

    task automatic word_is(input string tag,
                           input logic idx,
                           input logic [15:0] exp);
        data_req_idx = idx;
        #1;
        chk(tag, {16'h0, data}, {16'h0, exp});
    endtask

    initial begin
        rst            = 1'b1;
        sample_data    = '0;
        sample_valid   = 1'b0;
        event_consumed = 1'b0;
        data_req_idx   = 1'b0;
        data_req_valid = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        chk("rst_avail", {31'h0, event_available}, 32'h0);
        chk("rst_ovf", {31'h0, overflow}, 32'h0);
        chk("rst_data", {16'h0, data}, 32'h0);
        chk("rst_nw", {30'h0, data_num_words}, 32'd2);

        // Single sample round trip.
        push(32'hBEEF_1234);
        chk("one_avail", {31'h0, event_available}, 32'h1);
        chk("one_nw", {30'h0, data_num_words}, 32'd2);
        word_is("one_w0", 1'b0, 16'h1234);
        word_is("one_w1", 1'b1, 16'hBEEF);
        data_req_idx = 1'b0;
        pop();
        chk("one_empty", {31'h0, event_available}, 32'h0);
        chk("one_edata", {16'h0, data}, 32'h0);

        // Fill, three drops, then drain to the overflow record.
        for (int i = 0; i < 16; i++)
            push(32'h1000_0000 | (i << 16) | (32'h100 + i));
        for (int i = 0; i < 3; i++)
            push(32'hDEAD_0000 + i);
        word_is("fill_head", 1'b0, 16'h0100);
        pop();
        for (int i = 1; i < 16; i++) begin
            word_is($sformatf("drain_w0_%0d", i), 1'b0,
                    16'h0100 + 16'(i));
            pop();
        end
        chk("ovf3_flag", {31'h0, overflow}, 32'h1);
        chk("ovf3_nw", {30'h0, data_num_words}, 32'd1);
        word_is("ovf3_data", 1'b1, 16'h0003);
        data_req_idx = 1'b0;
        pop();
        chk("ovf3_empty", {31'h0, event_available}, 32'h0);

        // Full with no drops: push and pop together.
        for (int i = 0; i < 16; i++)
            push(32'hA000_0000 + i);
        push_pop(32'hCAFE_0016);
        word_is("pp_head", 1'b0, 16'h0001);
        for (int i = 1; i < 16; i++) pop();
        word_is("pp_new_w1", 1'b1, 16'hCAFE);
        chk("pp_new_ovf", {31'h0, overflow}, 32'h0);
        data_req_idx = 1'b0;
        pop();
        chk("pp_empty", {31'h0, event_available}, 32'h0);

        // Five drops, then record write collides with a sample.
        for (int i = 0; i < 16; i++)
            push(32'hB000_0000 + i);
        for (int i = 0; i < 5; i++)
            push(32'hEEEE_0000 + i);
        push_pop(32'hDEAD_BEEF);
        word_is("c5_head", 1'b0, 16'h0001);
        for (int i = 1; i < 16; i++) pop();
        chk("c5_flag", {31'h0, overflow}, 32'h1);
        word_is("c5_data", 1'b0, 16'h0005);
        pop();
        chk("c1_flag", {31'h0, overflow}, 32'h1);
        word_is("c1_data", 1'b0, 16'h0001);
        pop();
        chk("c1_empty", {31'h0, event_available}, 32'h0);

        // Saturating drop counter.
        for (int i = 0; i < 16; i++)
            push(32'hC000_0000 + i);
        sample_data  = 32'h5555_5555;
        sample_valid = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        sample_valid = 1'b0;
        for (int i = 0; i < 16; i++) pop();
        chk("sat_flag", {31'h0, overflow}, 32'h1);
        word_is("sat_data", 1'b0, 16'hFFFF);
        pop();
        chk("sat_empty", {31'h0, event_available}, 32'h0);

        // Reset while full with pending drops.
        for (int i = 0; i < 16; i++)
            push(32'hD000_0000 + i);
        push(32'h7777_0000);
        push(32'h7777_0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_avail", {31'h0, event_available}, 32'h0);
        chk("mrst_data", {16'h0, data}, 32'h0);
        push(32'h1234_5678);
        chk("mrst_ovf", {31'h0, overflow}, 32'h0);
        chk("mrst_nw", {30'h0, data_num_words}, 32'd2);
        word_is("mrst_w0", 1'b0, 16'h5678);
        pop();
        chk("mrst_empty", {31'h0, event_available}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
